// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the pipelined core's data port. It replaces a
// plain data memory and provides:
//   - a word-addressed data RAM at byte addresses 0 .. 4*RAM_WORDS-1
//   - a 16-byte MMIO window at MMIO_BASE:
//       +0x0 CYCLE   free-running 32-bit cycle counter (write loads it)
//       +0x4 TXDATA  write pushes WriteData[7:0] into the TX FIFO, reads 0
//       +0x8 STATUS  [0] empty, [1] full, [5:2] count, [8] overflow,
//                    [9] bad_access; write-1-to-clear for [8] and [9]
//       +0xC         reserved: reads 0, writes ignored
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   reset      asynchronous, active-low reset
//   MemWrite   store strobe, sampled at posedge
//   ALUResult  byte address; bits [1:0] ignored (word accesses only)
//   WriteData  store data
//   ReadData   combinational read data for the current ALUResult
//   tx_data    TX FIFO head byte (0 while empty)
//   tx_valid   TX FIFO non-empty
//   tx_ready   consumer takes the head byte this cycle
//   bad_access sticky: a store hit an unmapped address
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bad_access
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    REG_CYCLE  = 2'd0,
    REG_TXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } mmio_reg_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic              ram_hit;
  logic              mmio_hit;
  mmio_reg_e         mmio_sel;
  logic [RAM_AW-1:0] ram_idx;

  // The byte offset inside a word carries no meaning here.
  logic unused_byte_offset;
  assign unused_byte_offset = ^ALUResult[1:0];

  assign ram_hit  = ALUResult[31:2] < 30'(RAM_WORDS);
  assign mmio_hit = ALUResult[31:4] == MMIO_BASE[31:4];
  assign mmio_sel = mmio_reg_e'(ALUResult[3:2]);
  assign ram_idx  = ALUResult[RAM_AW+1:2];

  logic wr_ram, wr_cycle, wr_tx, wr_status, wr_unmapped;

  assign wr_ram      = MemWrite && ram_hit;
  assign wr_cycle    = MemWrite && mmio_hit && (mmio_sel == REG_CYCLE);
  assign wr_tx       = MemWrite && mmio_hit && (mmio_sel == REG_TXDATA);
  assign wr_status   = MemWrite && mmio_hit && (mmio_sel == REG_STATUS);
  // The reserved MMIO slot is mapped, so a store there is not a bad access.
  assign wr_unmapped = MemWrite && !ram_hit && !mmio_hit;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      ram_q  [RAM_WORDS];
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic [31:0]      cycle_q,    cycle_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             overflow_q, overflow_d;
  logic             bad_q,      bad_d;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic fifo_empty, fifo_full, pop, push_ok, overflow_set;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop          = !fifo_empty && tx_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle:
  // the freed slot is the one the write pointer already points at.
  assign push_ok      = wr_tx && (!fifo_full || pop);
  assign overflow_set = wr_tx && fifo_full && !pop;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it holding a value (which would be a latch).
  always_comb begin
    cycle_d    = cycle_q + 32'd1;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    bad_d      = bad_q;

    if (wr_cycle) begin
      cycle_d = WriteData;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    if (wr_status && WriteData[8]) begin
      overflow_d = 1'b0;
    end
    if (overflow_set) begin
      overflow_d = 1'b1;
    end
    if (wr_status && WriteData[9]) begin
      bad_d = 1'b0;
    end
    if (wr_unmapped) begin
      bad_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      bad_q      <= bad_d;
    end
  end

  // NOTE: storage arrays have no reset; their contents only matter once
  // written (RAM) or once counted as valid (FIFO), so a reset would just cost
  // logic and keep them out of RAM macros.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram_q[ram_idx] <= WriteData;
    end
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= WriteData[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;

  always_comb begin
    status_word      = '0;
    status_word[0]   = fifo_empty;
    status_word[1]   = fifo_full;
    status_word[5:2] = 4'(count_q);
    status_word[8]   = overflow_q;
    status_word[9]   = bad_q;
  end

  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_sel)
        REG_CYCLE:  ReadData = cycle_q;
        REG_STATUS: ReadData = status_word;
        default:    ReadData = '0;
      endcase
    end
  end

  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign bad_access = bad_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. A transaction-level model (byte queue,
// associative RAM, integer counter, two flags) tracks what the block must do;
// one compare process checks the outputs against it on every falling edge,
// and the stimulus adds hand-computed literal checks at key points.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int unsigned RAM_WORDS  = 64;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [31:0] BASE       = 32'h0000_0100;
  localparam logic [31:0] A_CYCLE    = BASE;
  localparam logic [31:0] A_TX       = BASE + 32'h4;
  localparam logic [31:0] A_STATUS   = BASE + 32'h8;
  localparam logic [31:0] A_RSVD     = BASE + 32'hC;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        MemWrite  = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic        tx_ready  = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        bad_access;

  int n_checks = 0;
  int n_errors = 0;

  dmem_responder #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MMIO_BASE (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .bad_access(bad_access)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_ram [int];
  logic [7:0]  m_q [$];
  logic [31:0] m_cnt = '0;
  bit          m_ovf = 1'b0;
  bit          m_bad = 1'b0;

  task automatic model_step();
    bit          pop, push, full, ld_cycle, ovf_set, ovf_clr, bad_set, bad_clr;
    logic [31:0] a;
    pop      = (m_q.size() != 0) && tx_ready;
    full     = (m_q.size() == FIFO_DEPTH);
    a        = ALUResult & ~32'h3;
    push     = 0;
    ld_cycle = 0;
    ovf_set  = 0;
    ovf_clr  = 0;
    bad_set  = 0;
    bad_clr  = 0;
    if (MemWrite) begin
      if (a < 4 * RAM_WORDS) m_ram[int'(a >> 2)] = WriteData;
      else if (a == A_CYCLE) begin
        m_cnt    = WriteData;
        ld_cycle = 1;
      end else if (a == A_TX) begin
        if (!full || pop) push = 1;
        else ovf_set = 1;
      end else if (a == A_STATUS) begin
        ovf_clr = WriteData[8];
        bad_clr = WriteData[9];
      end else if (a != A_RSVD) bad_set = 1;
    end
    if (!ld_cycle) m_cnt = m_cnt + 1;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(WriteData[7:0]);
    m_ovf = ovf_set || (m_ovf && !ovf_clr);
    m_bad = bad_set || (m_bad && !bad_clr);
  endtask

  // Returns 0 when the expected value is unknown (RAM word never written).
  function automatic bit model_read(input logic [31:0] addr, output logic [31:0] v);
    logic [31:0] a;
    int          n;
    a = addr & ~32'h3;
    n = m_q.size();
    v = '0;
    if (a < 4 * RAM_WORDS) begin
      if (!m_ram.exists(int'(a >> 2))) return 0;
      v = m_ram[int'(a >> 2)];
    end else if (a == A_CYCLE) begin
      v = m_cnt;
    end else if (a == A_STATUS) begin
      v = 32'(n == 0) | (32'(n == FIFO_DEPTH) << 1) | (32'(n) << 2)
        | (32'(m_ovf) << 8) | (32'(m_bad) << 9);
    end
    return 1;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_q.delete();
      m_cnt = '0;
      m_ovf = 0;
      m_bad = 0;
    end else begin
      model_step();
    end
  end

  // Compare process: outputs are stable at the falling edge.
  initial begin : compare
    logic [31:0] exp_rd;
    forever begin
      @(negedge clk);
      if (model_read(ALUResult, exp_rd)) check("read_data", ReadData, exp_rd);
      check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
      check("bad_access", 32'(bad_access), 32'(m_bad));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic rdy);
    @(negedge clk);
    #1;
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wd;
    tx_ready  = rdy;
  endtask

  initial begin : stim
    logic [7:0] drain4 [4];

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    ALUResult = A_CYCLE;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_bad", 32'(bad_access), 32'h0);
    check("rst_cycle", ReadData, 32'h0);
    reset = 1'b1;

    // RAM store / load
    cyc(1, 32'h008, 32'h1234_5678, 0);
    cyc(1, 32'h000, 32'h0BAD_F00D, 0);
    cyc(1, 32'h004, 32'hDEAD_BEEF, 0);
    cyc(0, 32'h004, 32'h0, 0);
    #1 check("lw_004", ReadData, 32'hDEAD_BEEF);
    cyc(0, 32'h008, 32'h0, 0);
    #1 check("lw_008", ReadData, 32'h1234_5678);
    check("ram_no_bad", 32'(bad_access), 32'h0);

    // Cycle counter load and wrap
    cyc(1, A_CYCLE, 32'hFFFF_FFFE, 0);
    cyc(0, A_CYCLE, 32'h0, 0);
    #1 check("cycle_0", ReadData, 32'hFFFF_FFFE);
    cyc(0, A_CYCLE, 32'h0, 0);
    #1 check("cycle_1", ReadData, 32'hFFFF_FFFF);
    cyc(0, A_CYCLE, 32'h0, 0);
    #1 check("cycle_wrap", ReadData, 32'h0000_0000);

    // Fill past full: fifth byte overflows
    for (int i = 0; i < 5; i++) cyc(1, A_TX, 32'h41 + 32'(i), 0);
    cyc(0, A_STATUS, 32'h0, 0);
    #1 check("status_full_ovf", ReadData, 32'h0000_0112);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h004, 32'h0, 1);
      #1 check("drain_a", 32'(tx_data), 32'h41 + 32'(i));
    end
    cyc(0, A_STATUS, 32'h0, 0);
    #1 check("drained_valid", 32'(tx_valid), 32'h0);
    check("status_empty_ovf", ReadData, 32'h0000_0101);

    // Push while full with a simultaneous pop
    cyc(1, A_STATUS, 32'h0000_0100, 0);
    for (int i = 0; i < 4; i++) cyc(1, A_TX, 32'h61 + 32'(i), 0);
    cyc(1, A_TX, 32'h55, 1);
    #1 check("head_at_swap", 32'(tx_data), 32'h61);
    cyc(0, A_STATUS, 32'h0, 0);
    #1 check("status_swap", ReadData, 32'h0000_0012);
    drain4 = '{8'h62, 8'h63, 8'h64, 8'h55};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h000, 32'h0, 1);
      #1 check("drain_b", 32'(tx_data), 32'(drain4[i]));
    end
    cyc(0, A_STATUS, 32'h0, 0);
    #1 check("status_empty", ReadData, 32'h0000_0001);

    // Unmapped store, W1C clear, reserved slot
    cyc(1, 32'h200, 32'hFFFF_FFFF, 0);
    cyc(0, A_STATUS, 32'h0, 0);
    #1 check("status_bad", ReadData, 32'h0000_0201);
    check("bad_set", 32'(bad_access), 32'h1);
    cyc(0, 32'h000, 32'h0, 0);
    #1 check("ram_alias_kept", ReadData, 32'h0BAD_F00D);
    cyc(0, 32'h200, 32'h0, 0);
    #1 check("unmapped_read", ReadData, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1, A_TX, 32'h71 + 32'(i), 0);
    cyc(0, A_STATUS, 32'h0, 0);
    #1 check("status_both", ReadData, 32'h0000_0312);
    cyc(1, A_STATUS, 32'h0000_0300, 0);
    cyc(0, A_STATUS, 32'h0, 0);
    #1 check("status_cleared", ReadData, 32'h0000_0012);
    cyc(1, A_STATUS, 32'h0000_0300, 0);
    cyc(1, A_TX, 32'h76, 0);
    cyc(0, A_STATUS, 32'h0, 0);
    #1 check("ovf_reset_after_clr", ReadData, 32'h0000_0112);
    cyc(1, A_RSVD, 32'hFFFF_FFFF, 0);
    cyc(0, A_RSVD, 32'h0, 0);
    #1 check("rsvd_read", ReadData, 32'h0);
    check("rsvd_not_bad", 32'(bad_access), 32'h0);

    // Reset mid-operation with 3 bytes queued
    cyc(0, 32'h000, 32'h0, 1);
    cyc(1, 32'h010, 32'hCAFE_F00D, 0);
    cyc(0, A_STATUS, 32'h0, 0);
    #1 check("status_three", ReadData, 32'h0000_010C);
    check("head_before_rst", 32'(tx_data), 32'h72);
    @(negedge clk);
    #1;
    reset     = 1'b0;
    ALUResult = A_CYCLE;
    #1;
    check("midrst_tx_valid", 32'(tx_valid), 32'h0);
    check("midrst_cycle", ReadData, 32'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    cyc(0, 32'h010, 32'h0, 0);
    #1 check("ram_kept", ReadData, 32'hCAFE_F00D);
    cyc(0, A_STATUS, 32'h0, 0);
    #1 check("status_after_rst", ReadData, 32'h0000_0001);

    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
